// File: rtl/secuenciador_init_param.sv
// Parametrised RTC init sequencer: emits N_PARES (address, data) byte pairs
// over a valid/ready handshake, data from TABLA or from a start-time snapshot.
module secuenciador_init_param #(
    parameter int DATA_W  = 8,
    parameter int N_PARES = 11,
    parameter logic [2*DATA_W*N_PARES-1:0] TABLA =
        176'hF000_4300_4200_4100_2600_2500_2400_2300_2200_2100_0216,
    localparam int IW = (N_PARES > 1) ? $clog2(N_PARES) : 1
) (
    input  logic                      reloj,
    input  logic                      resetM,
    input  logic                      inicio,
    input  logic                      modo,
    input  logic                      cancelar,
    input  logic [DATA_W*N_PARES-1:0] datos_in,
    input  logic                      listo_bus,
    output logic [DATA_W-1:0]         Inicie,
    output logic                      es_dir,
    output logic                      valido,
    output logic [IW-1:0]             indice,
    output logic                      ocupado,
    output logic                      fin
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIR  = 2'd1;
    localparam logic [1:0] DATO = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    localparam logic [IW-1:0] ULT = IW'(N_PARES - 1);

    logic [1:0]                estado;
    logic                      modo_r;
    logic [DATA_W*N_PARES-1:0] snap;
    logic [2*DATA_W-1:0]       par;
    logic [DATA_W-1:0]         dato;

    assign par  = TABLA[2*DATA_W*indice +: 2*DATA_W];
    assign dato = modo_r ? snap[DATA_W*indice +: DATA_W] : par[DATA_W-1:0];

    // Outputs decode from state only, so an async reset clears them at once.
    always_comb begin
        Inicie = '0;
        es_dir = 1'b0;
        valido = 1'b0;
        case (estado)
            DIR: begin
                Inicie = par[2*DATA_W-1:DATA_W];
                es_dir = 1'b1;
                valido = 1'b1;
            end
            DATO: begin
                Inicie = dato;
                valido = 1'b1;
            end
            default: ;
        endcase
    end

    assign ocupado = (estado != IDLE);
    assign fin     = (estado == FIN);

    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            estado <= IDLE;
            indice <= '0;
            modo_r <= 1'b0;
            snap   <= '0;
        end else begin
            case (estado)
                IDLE: begin
                    if (inicio && !cancelar) begin
                        estado <= DIR;
                        modo_r <= modo;
                        snap   <= datos_in;
                        indice <= '0;
                    end
                end
                DIR: begin
                    if (cancelar) begin
                        estado <= IDLE;
                        indice <= '0;
                    end else if (listo_bus) begin
                        estado <= DATO;
                    end
                end
                DATO: begin
                    // Abort wins over a transfer completing in the same cycle.
                    if (cancelar) begin
                        estado <= IDLE;
                        indice <= '0;
                    end else if (listo_bus) begin
                        if (indice == ULT) begin
                            estado <= FIN;
                        end else begin
                            indice <= indice + 1'b1;
                            estado <= DIR;
                        end
                    end
                end
                default: begin
                    estado <= IDLE;
                    indice <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_init_param.sv
// Directed bench for secuenciador_init_param: vector table plus
// hand-written sequences for stalls, snapshot, cancel, reset and N_PARES=1.
module tb_secuenciador_init_param;

    logic        reloj = 1'b0;
    logic        resetM = 1'b0;
    logic        inicio = 1'b0, modo = 1'b0, cancelar = 1'b0, listo_bus = 1'b0;
    logic [87:0] datos_in = '0;
    logic [7:0]  Inicie;
    logic        es_dir, valido, ocupado, fin;
    logic [3:0]  indice;

    logic        ini1 = 1'b0, mo1 = 1'b0, can1 = 1'b0, rdy1 = 1'b1;
    logic [7:0]  din1 = '0;
    logic [7:0]  b1;
    logic        d1, v1, o1, f1;
    logic [0:0]  x1;

    int n_chk = 0;
    int n_err = 0;

    always #5 reloj = ~reloj;

    secuenciador_init_param dut (
        .reloj(reloj), .resetM(resetM), .inicio(inicio), .modo(modo),
        .cancelar(cancelar), .datos_in(datos_in), .listo_bus(listo_bus),
        .Inicie(Inicie), .es_dir(es_dir), .valido(valido), .indice(indice),
        .ocupado(ocupado), .fin(fin)
    );

    secuenciador_init_param #(
        .DATA_W(8), .N_PARES(1), .TABLA(16'hA55A)
    ) dut1 (
        .reloj(reloj), .resetM(resetM), .inicio(ini1), .modo(mo1),
        .cancelar(can1), .datos_in(din1), .listo_bus(rdy1),
        .Inicie(b1), .es_dir(d1), .valido(v1), .indice(x1),
        .ocupado(o1), .fin(f1)
    );

    typedef struct {
        logic        ini, mo, can, rdy;
        logic [15:0] exp;
    } vec_t;

    vec_t tv[$];

    logic [7:0] b0   [22] = '{8'h02, 8'h16, 8'h21, 8'h00, 8'h22, 8'h00,
                              8'h23, 8'h00, 8'h24, 8'h00, 8'h25, 8'h00,
                              8'h26, 8'h00, 8'h41, 8'h00, 8'h42, 8'h00,
                              8'h43, 8'h00, 8'hF0, 8'h00};
    logic [7:0] dirs [11] = '{8'h02, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                              8'h26, 8'h41, 8'h42, 8'h43, 8'hF0};
    logic [7:0] dm1  [11] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                              8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB};

    function automatic logic [15:0] pk(input logic [7:0] b, input logic d,
                                       input logic v, input logic [3:0] x,
                                       input logic o, input logic f);
        return {b, d, v, x, o, f};
    endfunction

    function automatic logic [15:0] act();
        return pk(Inicie, es_dir, valido, indice, ocupado, fin);
    endfunction

    function automatic logic [15:0] act1();
        return pk(b1, d1, v1, {3'b000, x1}, o1, f1);
    endfunction

    task automatic chk(input string nm, input logic [15:0] a,
                       input logic [15:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic step();
        @(negedge reloj);
    endtask

    initial begin
        // Async reset from power-up, checked between edges
        #2 resetM = 1'b1;
        #1 chk("rst_async", act(), pk(8'h00, 0, 0, 4'd0, 0, 0));
        chk("rst_async_n1", act1(), pk(8'h00, 0, 0, 4'd0, 0, 0));
        step();
        resetM = 1'b0;

        // Table: mode 0 full run, then inicio blocked by cancelar
        tv.push_back('{1'b1, 1'b0, 1'b0, 1'b1, pk(8'h00, 0, 0, 4'd0, 0, 0)});
        for (int j = 0; j < 22; j++)
            tv.push_back('{1'b0, 1'b0, 1'b0, 1'b1,
                           pk(b0[j], (j % 2) == 0, 1, 4'(j / 2), 1, 0)});
        tv.push_back('{1'b0, 1'b0, 1'b0, 1'b1, pk(8'h00, 0, 0, 4'd10, 1, 1)});
        tv.push_back('{1'b1, 1'b0, 1'b1, 1'b1, pk(8'h00, 0, 0, 4'd0, 0, 0)});
        tv.push_back('{1'b0, 1'b0, 1'b0, 1'b1, pk(8'h00, 0, 0, 4'd0, 0, 0)});
        tv.push_back('{1'b0, 1'b0, 1'b0, 1'b1, pk(8'h00, 0, 0, 4'd0, 0, 0)});
        for (int i = 0; i < tv.size(); i++) begin
            step();
            chk($sformatf("vec%0d", i), act(), tv[i].exp);
            inicio    = tv[i].ini;
            modo      = tv[i].mo;
            cancelar  = tv[i].can;
            listo_bus = tv[i].rdy;
        end

        // Backpressure: 3 stall cycles on byte 2 (addr 21)
        step();
        inicio = 1'b1; modo = 1'b0; listo_bus = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            step();
            inicio = 1'b0;
            listo_bus = !(c >= 3 && c <= 5);
            if (c >= 3 && c <= 6)
                chk($sformatf("bp_hold%0d", c), act(),
                    pk(8'h21, 1, 1, 4'd1, 1, 0));
            if (c == 7)
                chk("bp_after", act(), pk(8'h00, 0, 1, 4'd1, 1, 0));
            if (c == 25)
                chk("bp_last", act(), pk(8'h00, 0, 1, 4'd10, 1, 0));
            if (c == 26)
                chk("bp_fin", act(), pk(8'h00, 0, 0, 4'd10, 1, 1));
            if (c == 27)
                chk("bp_idle", act(), pk(8'h00, 0, 0, 4'd0, 0, 0));
        end

        // Mode 1: snapshot taken at start edge, later bus changes ignored
        for (int k = 0; k < 11; k++) datos_in[8*k +: 8] = dm1[k];
        inicio = 1'b1; modo = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            step();
            inicio = 1'b0; modo = 1'b0;
            datos_in = '1;
            if (c <= 22) begin
                if ((c - 1) % 2 == 0)
                    chk($sformatf("m1_dir%0d", c), act(),
                        pk(dirs[(c - 1) / 2], 1, 1, 4'((c - 1) / 2), 1, 0));
                else
                    chk($sformatf("m1_dat%0d", c), act(),
                        pk(dm1[(c - 1) / 2], 0, 1, 4'((c - 1) / 2), 1, 0));
            end
            if (c == 23)
                chk("m1_fin", act(), pk(8'h00, 0, 0, 4'd10, 1, 1));
            if (c == 24)
                chk("m1_idle", act(), pk(8'h00, 0, 0, 4'd0, 0, 0));
        end

        // Cancel while presenting pair 4 data, then inicio+cancelar blocked
        inicio = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            step();
            inicio = 1'b0;
            cancelar = 1'b0;
            if (c == 10) begin
                chk("can_pre", act(), pk(8'h00, 0, 1, 4'd4, 1, 0));
                cancelar = 1'b1;
            end
            if (c == 11) begin
                chk("can_idle", act(), pk(8'h00, 0, 0, 4'd0, 0, 0));
                cancelar = 1'b1;
                inicio = 1'b1;
            end
            if (c == 12)
                chk("can_block", act(), pk(8'h00, 0, 0, 4'd0, 0, 0));
            if (c == 13)
                chk("can_nofin", act(), pk(8'h00, 0, 0, 4'd0, 0, 0));
        end

        // Async reset mid-sequence in DATO, pair 5
        inicio = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            inicio = 1'b0;
        end
        chk("rst_pre", act(), pk(8'h00, 0, 1, 4'd5, 1, 0));
        #2 resetM = 1'b1;
        #1 chk("rst_mid", act(), pk(8'h00, 0, 0, 4'd0, 0, 0));
        step();
        chk("rst_hold", act(), pk(8'h00, 0, 0, 4'd0, 0, 0));
        resetM = 1'b0;
        step();
        chk("rst_rel", act(), pk(8'h00, 0, 0, 4'd0, 0, 0));

        // N_PARES=1 variant; inicio during the sequence is ignored
        ini1 = 1'b1;
        step();
        chk("n1_dir", act1(), pk(8'hA5, 1, 1, 4'd0, 1, 0));
        step();
        chk("n1_dat", act1(), pk(8'h5A, 0, 1, 4'd0, 1, 0));
        step();
        chk("n1_fin", act1(), pk(8'h00, 0, 0, 4'd0, 1, 1));
        ini1 = 1'b0;
        step();
        chk("n1_idle", act1(), pk(8'h00, 0, 0, 4'd0, 0, 0));
        step();
        chk("n1_idle2", act1(), pk(8'h00, 0, 0, 4'd0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
